mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- MEM-stage data-memory sequencer for the LC-3b pipeline.
- Consumes the control word fields latched in the EX/MEM register: opcode, mem2_read, mem2_write, plus the ALU-computed address and store data.
- Drives the data-memory port through a request/response handshake and performs the double access for LDI/STI.
- Formats byte lanes for LDB/STB, returns load data, and stalls the pipeline until the access completes.

Parameters:
- WIDTH, 16, data and address width in bits. Fixed by the LC-3b; do not change.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- valid_in  in  1  EX/MEM holds a valid instruction.
- opcode  in  4  ctrl.opcode from EX/MEM.
- mem_read  in  1  ctrl.mem2_read.
- mem_write  in  1  ctrl.mem2_write.
- addr  in  16  effective address from the ALU.
- store_data  in  16  SR value for stores.
- dmem_address  out  16  memory address.
- dmem_read  out  1  read request.
- dmem_write  out  1  write request.
- dmem_byte_enable  out  2  byte enables; bit1 = high byte.
- dmem_wdata  out  16  write data.
- dmem_rdata  in  16  read data, valid with dmem_resp.
- dmem_resp  in  1  access complete.
- load_data  out  16  formatted load result, valid when done=1.
- done  out  1  one-cycle pulse when the instruction's final access completes.
- stall  out  1  holds all upstream pipeline registers.

Behaviour:
- Start condition: start = valid_in & (mem_read | mem_write), sampled in IDLE only.
- Priority: if both mem_read and mem_write are set, the write wins.
- State machine: IDLE, ACC1, GAP, ACC2.
  - IDLE --start--> ACC1. On this edge, latch opcode, addr, store_data and the write flag.
  - ACC1 --resp, non-indirect--> IDLE.
  - ACC1 --resp, LDI (1010) or STI (1011)--> GAP. Capture dmem_rdata into the pointer register.
  - GAP --> ACC2, unconditionally.
  - ACC2 --resp--> IDLE.
- Request signals:
  - Asserted only in ACC1 and ACC2.
  - Held stable (address, data, enables) until dmem_resp.
  - All deasserted in IDLE and GAP; GAP guarantees one low cycle between the two indirect accesses.
- ACC1 access:
  - Address is the latched addr.
  - For LDI/STI it is always a word read.
  - Otherwise it is a read or write per the latched write flag.
- ACC2 access:
  - Address is the pointer register with bit0 forced to 0, byte_enable 11.
  - Word read for LDI; write of store_data for STI.
- Byte formatting:
  - LDB (0010) / STB (0011): dmem_address = addr with bit0 cleared; byte_enable = addr[0] ? 10 : 01.
  - STB: dmem_wdata = {store_data[7:0], store_data[7:0]}.
  - LDB: load_data = zero-extend of the selected byte.
  - All other opcodes: word access, address bit0 cleared, byte_enable 11, load_data = dmem_rdata.
- Final access: ACC1 for non-indirect ops, ACC2 for indirect ops. finish = final-access state & dmem_resp.
  - done = finish.
  - load_data is the formatted dmem_rdata, combinational in the finish cycle; 0 otherwise.
- stall = (IDLE & start) | (state != IDLE & ~finish). stall is low in the finish cycle so EX/MEM advances on that edge.
- Latency: request first appears the cycle after start.
  - Single access with resp k cycles after request assertion (k ≥ 0): stall high for k+1 cycles.
  - Indirect: two such intervals plus one GAP cycle.
- Non-memory instructions and valid_in = 0 in IDLE: no stall, no request.
- dmem_resp in IDLE or GAP is ignored.
- Inputs are ignored while not in IDLE; the pipeline is stalled, so they are stable.
- Reset (asynchronous, any state) values:
  - state = IDLE.
  - dmem_address = 0, dmem_read = 0, dmem_write = 0, dmem_byte_enable = 00, dmem_wdata = 0.
  - load_data = 0, done = 0, stall = 0.
  - Pointer and latch registers = 0.
  - A response arriving after reset is ignored.

Test Plan:
- LDR (0110), addr 0x1235, resp 2 cycles after request, rdata 0xBEEF -> dmem_address 0x1234, byte_enable 11, read high 3 cycles, stall high 3 cycles, done 1 cycle with load_data 0xBEEF.
- LDB, addr 0x2001, rdata 0xA55A, resp same cycle as request -> byte_enable 10, load_data 0x00A5, stall 1 cycle. Repeat at addr 0x2000 -> byte_enable 01, load_data 0x005A.
- STB, addr 0x3000, store_data 0x12CD -> write with dmem_wdata 0xCDCD, byte_enable 01, done pulse, read never asserted.
- LDI, addr 0x4000, first rdata 0x5001, second rdata 0x7777 -> read @0x4000; one cycle with read low (GAP); read @0x5000; done with load_data 0x7777; single done pulse.
- STI, addr 0x4000 → pointer 0x6000, store_data 0x0BAD -> read @0x4000, GAP, write @0x6000 with wdata 0x0BAD, byte_enable 11.
- Assert reset_n low during ACC2 of an LDI -> all outputs 0 immediately and state IDLE; a late dmem_resp is ignored; a following ADD produces no stall; a subsequent LDR completes normally.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Data-memory port of the MEM-stage sequencer: request/response handshake
// with byte enables. The sequencer is the master; the memory model is the slave.
interface mem_access_unit_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] dmem_address;
  logic             dmem_read;
  logic             dmem_write;
  logic [1:0]       dmem_byte_enable;
  logic [WIDTH-1:0] dmem_wdata;
  logic [WIDTH-1:0] dmem_rdata;
  logic             dmem_resp;

  modport master (
    output dmem_address, dmem_read, dmem_write, dmem_byte_enable, dmem_wdata,
    input  dmem_rdata, dmem_resp
  );

  modport slave (
    input  dmem_address, dmem_read, dmem_write, dmem_byte_enable, dmem_wdata,
    output dmem_rdata, dmem_resp
  );
endinterface

// File: rtl/mem_access_unit.sv
// LC-3b MEM-stage data-memory sequencer: single or indirect (LDI/STI) accesses,
// byte-lane formatting for LDB/STB, load data return and pipeline stall.
module mem_access_unit #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 valid_in,
  input  logic [3:0]           opcode,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic [WIDTH-1:0]     addr,
  input  logic [WIDTH-1:0]     store_data,
  mem_access_unit_if.master    dmem,
  output logic [WIDTH-1:0]     load_data,
  output logic                 done,
  output logic                 stall
);

  localparam logic [3:0] op_ldb = 4'b0010;
  localparam logic [3:0] op_stb = 4'b0011;
  localparam logic [3:0] op_ldi = 4'b1010;
  localparam logic [3:0] op_sti = 4'b1011;

  typedef enum logic [1:0] {
    st_idle,
    st_acc1,
    st_gap,
    st_acc2
  } state_t;

  state_t           state_reg, state_next;
  logic [3:0]       opcode_reg;
  logic [WIDTH-1:0] addr_reg;
  logic [WIDTH-1:0] sdata_reg;
  logic             write_reg;
  logic [WIDTH-1:1] ptr_reg;

  logic             start;
  logic             is_indirect;
  logic             is_byte;
  logic             finish;
  logic [1:0]       lane_be;
  logic [WIDTH-1:0] lane_wdata;
  logic [7:0]       rbyte [2];
  logic [7:0]       sel_byte;

  // Gated by reset_n so stall stays low while reset is held.
  assign start       = reset_n & valid_in & (mem_read | mem_write);
  assign is_indirect = (opcode_reg == op_ldi) || (opcode_reg == op_sti);
  assign is_byte     = (opcode_reg == op_ldb) || (opcode_reg == op_stb);

  // Per-lane enable, store data replication and read byte extraction.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
      localparam logic lane_hi = (gi == 1);
      assign lane_be[gi]           = ~is_byte | (addr_reg[0] == lane_hi);
      assign lane_wdata[gi*8 +: 8] = is_byte ? sdata_reg[7:0] : sdata_reg[gi*8 +: 8];
      assign rbyte[gi]             = dmem.dmem_rdata[gi*8 +: 8];
    end
  endgenerate

  assign sel_byte = rbyte[addr_reg[0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= st_idle;
      opcode_reg <= '0;
      addr_reg   <= '0;
      sdata_reg  <= '0;
      write_reg  <= 1'b0;
      ptr_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == st_idle && start) begin
        opcode_reg <= opcode;
        addr_reg   <= addr;
        sdata_reg  <= store_data;
        write_reg  <= mem_write;
      end
      if (state_reg == st_acc1 && dmem.dmem_resp && is_indirect) begin
        ptr_reg <= dmem.dmem_rdata[WIDTH-1:1];
      end
    end
  end

  always_comb begin
    state_next            = state_reg;
    dmem.dmem_address     = '0;
    dmem.dmem_read        = 1'b0;
    dmem.dmem_write       = 1'b0;
    dmem.dmem_byte_enable = 2'b00;
    dmem.dmem_wdata       = '0;
    finish                = 1'b0;

    case (state_reg)
      st_idle: begin
        if (start) state_next = st_acc1;
      end
      st_acc1: begin
        dmem.dmem_address = {addr_reg[WIDTH-1:1], 1'b0};
        if (is_indirect) begin
          // First half of LDI/STI always fetches the pointer word.
          dmem.dmem_read        = 1'b1;
          dmem.dmem_byte_enable = 2'b11;
        end else begin
          dmem.dmem_byte_enable = lane_be;
          if (write_reg) begin
            dmem.dmem_write = 1'b1;
            dmem.dmem_wdata = lane_wdata;
          end else begin
            dmem.dmem_read = 1'b1;
          end
        end
        if (dmem.dmem_resp) begin
          if (is_indirect) begin
            state_next = st_gap;
          end else begin
            state_next = st_idle;
            finish     = 1'b1;
          end
        end
      end
      st_gap: begin
        state_next = st_acc2;
      end
      st_acc2: begin
        dmem.dmem_address     = {ptr_reg, 1'b0};
        dmem.dmem_byte_enable = 2'b11;
        if (opcode_reg == op_sti) begin
          dmem.dmem_write = 1'b1;
          dmem.dmem_wdata = sdata_reg;
        end else begin
          dmem.dmem_read = 1'b1;
        end
        if (dmem.dmem_resp) begin
          state_next = st_idle;
          finish     = 1'b1;
        end
      end
      default: begin
        state_next = st_idle;
      end
    endcase
  end

  // Stall drops in the finish cycle so EX/MEM advances on that edge.
  always_comb begin
    stall     = (state_reg == st_idle) ? start : ~finish;
    done      = finish;
    load_data = '0;
    if (finish) begin
      load_data = is_byte ? {{(WIDTH-8){1'b0}}, sel_byte} : dmem.dmem_rdata;
    end
  end

endmodule
